// File: rtl/dataflow_fork_reg.sv
// Registered eager fork: one valid/ready input token is broadcast to NUM_OUTPUTS branches.
// Latency 1 cycle; each branch drains on its own and input stalls only on occupied, non-ready branches.
module dataflow_fork_reg #(
  parameter int WIDTH       = 32,
  parameter int NUM_OUTPUTS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic [NUM_OUTPUTS-1:0]       out_valid,
  input  logic [NUM_OUTPUTS-1:0]       out_ready,
  output logic [NUM_OUTPUTS*WIDTH-1:0] out_data
);

  if (NUM_OUTPUTS < 1) begin : g_bad_num_outputs
    $error("dataflow_fork_reg: NUM_OUTPUTS must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("dataflow_fork_reg: WIDTH must be >= 1");
  end

  logic [WIDTH-1:0]       data_q;
  logic [NUM_OUTPUTS-1:0] occ_q;
  logic                   live_q;
  logic                   accept;

  // A branch can take a new token if it is empty or drains this cycle.
  assign in_ready = live_q & (&(~occ_q | out_ready));
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      occ_q  <= '0;
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (accept) begin
        data_q <= in_data;
        occ_q  <= '1;
      end else begin
        occ_q  <= occ_q & ~out_ready;
      end
    end
  end

  assign out_valid = occ_q;

  for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_out
    assign out_data[i*WIDTH +: WIDTH] = data_q;
  end

endmodule
